// File: rtl/nand_cmd_sequencer_if.sv
// rtl/nand_cmd_sequencer_if.sv - request, latch-unit and R/B# signals of the NAND command sequencer
interface nand_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd1;
  logic [2:0]  req_naddr;
  logic [39:0] req_addr;
  logic        req_has_cmd2;
  logic [7:0]  req_cmd2;
  logic        req_wait_rb;
  logic        done;
  logic        error;
  logic        busy;
  logic        lu_activate;
  logic [15:0] lu_data;
  logic        lu_type;
  logic        lu_busy;
  logic        nand_rb;

  modport slave (
    input  req_valid, req_cmd1, req_naddr, req_addr, req_has_cmd2, req_cmd2, req_wait_rb,
    input  lu_busy, nand_rb,
    output req_ready, done, error, busy, lu_activate, lu_data, lu_type
  );

  modport master (
    output req_valid, req_cmd1, req_naddr, req_addr, req_has_cmd2, req_cmd2, req_wait_rb,
    output lu_busy, nand_rb,
    input  req_ready, done, error, busy, lu_activate, lu_data, lu_type
  );
endinterface

// File: rtl/nand_cmd_sequencer.sv
// rtl/nand_cmd_sequencer.sv - sequences one NAND command/address transaction through a latch unit
module nand_cmd_sequencer #(
  parameter int T_WB        = 20,
  parameter int RB_TIMEOUT  = 1048576,
  parameter int ACK_TIMEOUT = 4
) (
  input logic                 clk,
  input logic                 nreset,
  nand_cmd_sequencer_if.slave bus
);

  // One counter is shared by the ACK wait, the t_WB wait and the R/B# wait;
  // they never overlap, so it is sized for the largest of them.
  localparam int CNT_W = $clog2(RB_TIMEOUT + T_WB + ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_ADDR, S_CMD2, S_WB, S_WAIT_RB, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_ISSUE, P_ACK, P_RELEASE
  } phase_t;

  state_t             state, state_n;
  phase_t             phase, phase_n;
  logic [2:0]         idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               err_r, err_n;

  logic [7:0]         cmd1_r;
  logic [2:0]         naddr_r;
  logic [39:0]        addr_r;
  logic               has_cmd2_r;
  logic [7:0]         cmd2_r;
  logic               wait_rb_r;

  logic               rb_meta, rb_sync;
  logic [7:0]         addr_byte;
  logic [7:0]         lu_byte;
  logic               latch_state;
  logic               illegal;
  logic               accept;

  assign accept      = (state == S_IDLE) && bus.req_valid;
  assign illegal     = (naddr_r > 3'd5);
  assign latch_state = (state == S_CMD1) || (state == S_ADDR) || (state == S_CMD2);

  // Two-flop synchroniser for the asynchronous R/B# pin; idles at "ready".
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rb_meta <= 1'b1;
      rb_sync <= 1'b1;
    end else begin
      rb_meta <= bus.nand_rb;
      rb_sync <= rb_meta;
    end
  end

  // Capture the whole request on acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmd1_r     <= '0;
      naddr_r    <= '0;
      addr_r     <= '0;
      has_cmd2_r <= 1'b0;
      cmd2_r     <= '0;
      wait_rb_r  <= 1'b0;
    end else if (accept) begin
      cmd1_r     <= bus.req_cmd1;
      naddr_r    <= bus.req_naddr;
      addr_r     <= bus.req_addr;
      has_cmd2_r <= bus.req_has_cmd2;
      cmd2_r     <= bus.req_cmd2;
      wait_rb_r  <= bus.req_wait_rb;
    end
  end

  // FSM state, handshake sub-phase, byte index, shared counter and error flag.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= S_IDLE;
      phase <= P_ISSUE;
      idx   <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      err_r <= err_n;
    end
  end

  // Select the address byte for the current index (byte 0 goes out first).
  always_comb begin
    addr_byte = 8'h00;
    case (idx)
      3'd0:    addr_byte = addr_r[7:0];
      3'd1:    addr_byte = addr_r[15:8];
      3'd2:    addr_byte = addr_r[23:16];
      3'd3:    addr_byte = addr_r[31:24];
      3'd4:    addr_byte = addr_r[39:32];
      default: addr_byte = 8'h00;
    endcase
  end

  // Next-state logic and all outputs.
  always_comb begin
    state_n         = state;
    phase_n         = phase;
    idx_n           = idx;
    cnt_n           = cnt;
    err_n           = err_r;
    lu_byte         = 8'h00;
    bus.lu_type     = 1'b0;
    bus.lu_activate = 1'b0;
    bus.req_ready   = (state == S_IDLE);
    bus.busy        = (state != S_IDLE);
    bus.done        = (state == S_DONE);
    bus.error       = (state == S_DONE) && err_r;

    // Data and type are a function of the state only, so they hold for the
    // whole ISSUE/ACK/RELEASE span of a byte.
    case (state)
      S_CMD1: begin lu_byte = cmd1_r;    bus.lu_type = 1'b1; end
      S_ADDR: begin lu_byte = addr_byte; bus.lu_type = 1'b0; end
      S_CMD2: begin lu_byte = cmd2_r;    bus.lu_type = 1'b1; end
      default: ;
    endcase

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_n = S_CMD1;
          phase_n = P_ISSUE;
          idx_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b0;
        end
      end

      S_CMD1, S_ADDR, S_CMD2: begin
        case (phase)
          P_ISSUE: begin
            // An illegal address count is caught before any latch activity.
            if ((state == S_CMD1) && illegal) begin
              state_n = S_DONE;
              err_n   = 1'b1;
            end else begin
              bus.lu_activate = 1'b1;
              phase_n         = P_ACK;
              cnt_n           = '0;
            end
          end
          P_ACK: begin
            if (bus.lu_busy) begin
              phase_n = P_RELEASE;
            end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              state_n = S_DONE;
              err_n   = 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          default: begin
            // RELEASE: the cycle spent here is the gap before the next ISSUE.
            if (!bus.lu_busy) begin
              phase_n = P_ISSUE;
              cnt_n   = '0;
              if ((state == S_CMD1) && (naddr_r != 3'd0)) begin
                state_n = S_ADDR;
                idx_n   = '0;
              end else if ((state == S_ADDR) && (idx != naddr_r - 3'd1)) begin
                idx_n = idx + 3'd1;
              end else if ((state != S_CMD2) && has_cmd2_r) begin
                state_n = S_CMD2;
              end else begin
                state_n = S_WB;
              end
            end
          end
        endcase
      end

      S_WB: begin
        if (cnt == CNT_W'(T_WB - 1)) begin
          cnt_n   = '0;
          state_n = wait_rb_r ? S_WAIT_RB : S_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_WAIT_RB: begin
        if (rb_sync) begin
          state_n = S_DONE;
        end else if (cnt == CNT_W'(RB_TIMEOUT - 1)) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    bus.lu_data = {8'h00, lu_byte};
  end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb/tb_nand_cmd_sequencer.sv - randomized self-checking bench for nand_cmd_sequencer
module tb_nand_cmd_sequencer;
  localparam int T_WB   = 20;
  localparam int RB_TO  = 64;
  localparam int ACK_TO = 4;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  nand_cmd_sequencer_if bus();

  nand_cmd_sequencer #(.T_WB(T_WB), .RB_TIMEOUT(RB_TO), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [16:0] got_q[$];
  int n_done = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;
  int first_act_cyc = 0;
  int n_falls = 0;
  int last_fall = 0;
  bit lu_dead = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Observe latch activity, done pulses and error isolation mid-cycle.
  always @(negedge clk) begin
    if (bus.lu_activate) begin
      if (got_q.size() == 0) first_act_cyc = cyc;
      got_q.push_back({bus.lu_type, bus.lu_data});
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
      done_err = bus.error;
    end
    if (bus.error) check_eq("err_iso", {63'd0, bus.done}, 64'd1);
  end

  // Latch unit model: random ack delay and busy length, checks data hold.
  initial begin
    bus.lu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.lu_activate && !lu_dead) begin
        logic [16:0] held;
        int d;
        int l;
        held = {bus.lu_type, bus.lu_data};
        d = $urandom_range(0, 2);
        l = $urandom_range(1, 4);
        repeat (d + 1) @(posedge clk);
        #1 bus.lu_busy = 1'b1;
        repeat (l) @(posedge clk);
        #1 bus.lu_busy = 1'b0;
        if (nreset) check_eq("hold", {47'd0, bus.lu_type, bus.lu_data}, {47'd0, held});
        n_falls++;
        last_fall = cyc;
      end
    end
  end

  task automatic drive_req(input logic [7:0] c1, input logic [2:0] na, input logic [39:0] ad,
                           input logic h2, input logic [7:0] c2, input logic wr);
    bus.req_cmd1     = c1;
    bus.req_naddr    = na;
    bus.req_addr     = ad;
    bus.req_has_cmd2 = h2;
    bus.req_cmd2     = c2;
    bus.req_wait_rb  = wr;
    bus.req_valid    = 1'b1;
  endtask

  task automatic scramble_req();
    bus.req_valid    = 1'b0;
    bus.req_cmd1     = 8'($urandom);
    bus.req_naddr    = 3'($urandom);
    bus.req_addr     = {8'($urandom), $urandom};
    bus.req_has_cmd2 = 1'($urandom);
    bus.req_cmd2     = 8'($urandom);
    bus.req_wait_rb  = 1'($urandom);
  endtask

  // One transaction; k = cycles after the final latch release at which R/B#
  // goes high (-1 = never).
  task automatic run_txn(input logic [7:0] c1, input logic [2:0] na, input logic [39:0] ad,
                         input logic h2, input logic [7:0] c2, input logic wr,
                         input int k, input string tag);
    logic [16:0] exp_q[$];
    int acc_cyc;
    int exp_cyc;
    int e;
    logic exp_err;
    int nbytes;

    if (na <= 3'd5) begin
      exp_q.push_back({1'b1, 8'h00, c1});
      for (int i = 0; i < int'(na); i++) exp_q.push_back({1'b0, 8'h00, ad[8*i +: 8]});
      if (h2) exp_q.push_back({1'b1, 8'h00, c2});
    end
    if (lu_dead && exp_q.size() > 1) exp_q = exp_q[0:0];
    nbytes = exp_q.size();

    got_q.delete();
    n_done = 0;
    n_falls = 0;
    @(posedge clk);
    #1;
    drive_req(c1, na, ad, h2, c2, wr);
    bus.nand_rb = wr ? 1'b0 : 1'b1;

    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      check_eq({tag, "_accept"}, 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 scramble_req();
    @(negedge clk);
    check_eq({tag, "_ready_drop"}, {62'd0, bus.req_ready, bus.busy}, 64'd1);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      if (wr && k >= 0 && nbytes > 0 && n_falls == nbytes && cyc == last_fall + k) bus.nand_rb = 1'b1;
      if (n_done > 0) break;
    end
    repeat (3) @(posedge clk);
    #1;

    e = last_fall;
    if (na > 3'd5) begin
      exp_err = 1'b1;
      exp_cyc = acc_cyc + 2;
    end else if (lu_dead) begin
      exp_err = 1'b1;
      exp_cyc = first_act_cyc + ACK_TO + 1;
    end else if (!wr) begin
      exp_err = 1'b0;
      exp_cyc = e + T_WB + 1;
    end else if (k < 0) begin
      exp_err = 1'b1;
      exp_cyc = e + T_WB + 1 + RB_TO;
    end else begin
      exp_err = 1'b0;
      exp_cyc = (e + k + 3 > e + T_WB + 2) ? e + k + 3 : e + T_WB + 2;
    end

    check_eq({tag, "_done_cnt"}, 64'(n_done), 64'd1);
    check_eq({tag, "_err"}, {63'd0, done_err}, {63'd0, exp_err});
    check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_cyc));
    check_eq({tag, "_nbytes"}, 64'(got_q.size()), 64'(nbytes));
    for (int i = 0; i < nbytes && i < got_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), {47'd0, got_q[i]}, {47'd0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, {40'd0, bus.req_ready, bus.busy, bus.done, bus.error, bus.lu_activate, bus.lu_type, bus.lu_data},
             {40'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.nand_rb = 1'b1;
    scramble_req();
    #1 check_reset_outputs("reset_vals");
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;

    run_txn(8'hFF, 3'd0, 40'd0, 1'b0, 8'h00, 1'b1, 30, "ffh_reset");
    run_txn(8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, 1'b0, 0, "page_read");
    run_txn(8'h80, 3'd6, 40'h1122334455, 1'b1, 8'h10, 1'b1, 5, "naddr6");
    run_txn(8'h60, 3'd3, 40'h0000ABCDEF, 1'b1, 8'hD0, 1'b1, -1, "rb_timeout");
    lu_dead = 1'b1;
    run_txn(8'h90, 3'd1, 40'h0000000000, 1'b0, 8'h00, 1'b0, 0, "ack_timeout");
    lu_dead = 1'b0;

    // Reset during the address phase.
    begin
      int seen;
      got_q.delete();
      n_done = 0;
      @(posedge clk);
      #1 drive_req(8'h00, 3'd5, 40'h0A0B0C0D0E, 1'b1, 8'h30, 1'b0);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.req_ready == 1'b0) bus.req_valid = 1'b0;
        if (got_q.size() >= 3) begin
          seen = 1;
          break;
        end
      end
      check_eq("rst_reach_addr", 64'(seen), 64'd1);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #3 nreset = 1'b0;
      #1 check_reset_outputs("rst_async");
      for (int i = 0; i < 20 && bus.lu_busy; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      check_eq("rst_no_done", 64'(n_done), 64'd0);
      #1 nreset = 1'b1;
    end
    run_txn(8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, 1'b1, 10, "after_reset");

    for (int t = 0; t < 20; t++) begin
      logic [2:0] na;
      int k;
      na = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      k = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, T_WB + 62));
      run_txn(8'($urandom), na, {8'($urandom), $urandom}, 1'($urandom), 8'($urandom),
              1'($urandom), k, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
